// File: rtl/uart_cmd_pkg.sv
// Shared command codes, state encoding and operand addresses for the UART command sequencer.
package uart_cmd_pkg;

  localparam int unsigned CMD_W = 8;
  localparam int unsigned FUN_W = 4;

  localparam logic [CMD_W-1:0] CMD_RF_WR   = 8'hAA;
  localparam logic [CMD_W-1:0] CMD_RF_RD   = 8'hBB;
  localparam logic [CMD_W-1:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [CMD_W-1:0] CMD_ALU_NOP = 8'hDD;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    RD_SEND,
    OP_A,
    OP_B,
    OP_FUN,
    ALU_WAIT,
    SEND_LO,
    SEND_HI
  } state_e;

  // States during which the ALU clock must be running.
  function automatic logic alu_clk_needed(input state_e s);
    return (s inside {OP_A, OP_B, OP_FUN, ALU_WAIT});
  endfunction

endpackage

// File: rtl/uart_cmd_tx_push.sv
// Single-byte TX FIFO push handler: pushes one byte per request once the FIFO has room.
module uart_cmd_tx_push #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  txf_full,
  output logic [DATA_WIDTH-1:0] txf_wr_data,
  output logic                  txf_wr_inc,
  output logic                  done
);

  logic push_c;

  // A request is not re-honoured in the cycle its push strobe is out, which spaces pushes.
  assign push_c = req && !txf_full && !txf_wr_inc;
  assign done   = txf_wr_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txf_wr_inc  <= 1'b0;
      txf_wr_data <= '0;
    end else begin
      txf_wr_inc <= push_c;
      if (push_c) begin
        txf_wr_data <= data;
      end
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command sequencer: parses RX byte frames into RF writes/reads and ALU operations,
// and returns read data / ALU results as bytes pushed into the TX FIFO.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    ARSTn,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  output logic [ADDR_WIDTH-1:0]   RF_Address,
  output logic                    RF_WrEn,
  output logic                    RF_RdEn,
  output logic [DATA_WIDTH-1:0]   RF_WrData,
  input  logic [DATA_WIDTH-1:0]   RF_RdData,
  input  logic                    RF_RdData_VLD,
  output logic                    ALU_EN,
  output logic [FUN_W-1:0]        ALU_FUN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  output logic                    CLKG_EN,
  output logic [DATA_WIDTH-1:0]   TXF_WR_DATA,
  output logic                    TXF_WR_INC,
  input  logic                    TXF_FULL
);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic [2*DATA_WIDTH-1:0] alu_res_q, alu_res_d;

  logic [ADDR_WIDTH-1:0]   rf_addr_d;
  logic [DATA_WIDTH-1:0]   rf_wrdata_d;
  logic [FUN_W-1:0]        alu_fun_d;
  logic                    rf_wren_d, rf_rden_d, alu_en_d, clkg_en_d;

  logic                    push_req_c;
  logic [DATA_WIDTH-1:0]   push_data_c;
  logic                    push_done;

  // State and registered outputs.
  always_ff @(posedge clk or negedge ARSTn) begin
    if (!ARSTn) begin
      state_q    <= IDLE;
      rd_data_q  <= '0;
      alu_res_q  <= '0;
      RF_Address <= '0;
      RF_WrData  <= '0;
      RF_WrEn    <= 1'b0;
      RF_RdEn    <= 1'b0;
      ALU_EN     <= 1'b0;
      ALU_FUN    <= '0;
      CLKG_EN    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_data_q  <= rd_data_d;
      alu_res_q  <= alu_res_d;
      RF_Address <= rf_addr_d;
      RF_WrData  <= rf_wrdata_d;
      RF_WrEn    <= rf_wren_d;
      RF_RdEn    <= rf_rden_d;
      ALU_EN     <= alu_en_d;
      ALU_FUN    <= alu_fun_d;
      CLKG_EN    <= clkg_en_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    rd_data_d   = rd_data_q;
    alu_res_d   = alu_res_q;
    rf_addr_d   = RF_Address;
    rf_wrdata_d = RF_WrData;
    alu_fun_d   = ALU_FUN;
    rf_wren_d   = 1'b0;
    rf_rden_d   = 1'b0;
    alu_en_d    = 1'b0;
    push_req_c  = 1'b0;
    push_data_c = rd_data_q;

    case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == DATA_WIDTH'(CMD_RF_WR)) begin
            state_d = WR_ADDR;
          end else if (RX_P_DATA == DATA_WIDTH'(CMD_RF_RD)) begin
            state_d = RD_ADDR;
          end else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_OP)) begin
            state_d = OP_A;
          end else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_NOP)) begin
            state_d = OP_FUN;
          end
        end
      end

      WR_ADDR: begin
        if (RX_D_VLD) begin
          rf_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d   = WR_DATA;
        end
      end

      WR_DATA: begin
        if (RX_D_VLD) begin
          rf_wrdata_d = RX_P_DATA;
          rf_wren_d   = 1'b1;
          state_d     = IDLE;
        end
      end

      RD_ADDR: begin
        if (RX_D_VLD) begin
          rf_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
          rf_rden_d = 1'b1;
          state_d   = RD_WAIT;
        end
      end

      // A valid coincident with our own read strobe cannot belong to this request.
      RD_WAIT: begin
        if (RF_RdData_VLD && !RF_RdEn) begin
          rd_data_d = RF_RdData;
          state_d   = RD_SEND;
        end
      end

      RD_SEND: begin
        push_req_c  = !push_done;
        push_data_c = rd_data_q;
        if (push_done) begin
          state_d = IDLE;
        end
      end

      OP_A: begin
        if (RX_D_VLD) begin
          rf_addr_d   = ADDR_WIDTH'(OPA_ADDR);
          rf_wrdata_d = RX_P_DATA;
          rf_wren_d   = 1'b1;
          state_d     = OP_B;
        end
      end

      OP_B: begin
        if (RX_D_VLD) begin
          rf_addr_d   = ADDR_WIDTH'(OPB_ADDR);
          rf_wrdata_d = RX_P_DATA;
          rf_wren_d   = 1'b1;
          state_d     = OP_FUN;
        end
      end

      OP_FUN: begin
        if (RX_D_VLD) begin
          alu_fun_d = RX_P_DATA[FUN_W-1:0];
          alu_en_d  = 1'b1;
          state_d   = ALU_WAIT;
        end
      end

      ALU_WAIT: begin
        if (ALU_OUT_VLD && !ALU_EN) begin
          alu_res_d = ALU_OUT;
          state_d   = SEND_LO;
        end
      end

      SEND_LO: begin
        push_req_c  = !push_done;
        push_data_c = alu_res_q[DATA_WIDTH-1:0];
        if (push_done) begin
          state_d = SEND_HI;
        end
      end

      SEND_HI: begin
        push_req_c  = !push_done;
        push_data_c = alu_res_q[2*DATA_WIDTH-1:DATA_WIDTH];
        if (push_done) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    clkg_en_d = alu_clk_needed(state_d);
  end

  uart_cmd_tx_push #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_tx_push (
    .clk         (clk),
    .rst_n       (ARSTn),
    .req         (push_req_c),
    .data        (push_data_c),
    .txf_full    (TXF_FULL),
    .txf_wr_data (TXF_WR_DATA),
    .txf_wr_inc  (TXF_WR_INC),
    .done        (push_done)
  );

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed scenarios plus a randomized command stream
// checked against a command-level reference model.
module tb_uart_cmd_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  logic            clk = 1'b0;
  logic            ARSTn;
  logic [DW-1:0]   RX_P_DATA;
  logic            RX_D_VLD;
  logic [AW-1:0]   RF_Address;
  logic            RF_WrEn, RF_RdEn;
  logic [DW-1:0]   RF_WrData;
  logic [DW-1:0]   RF_RdData;
  logic            RF_RdData_VLD;
  logic            ALU_EN;
  logic [3:0]      ALU_FUN;
  logic [2*DW-1:0] ALU_OUT;
  logic            ALU_OUT_VLD;
  logic            CLKG_EN;
  logic [DW-1:0]   TXF_WR_DATA;
  logic            TXF_WR_INC;
  logic            TXF_FULL;

  uart_cmd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .ARSTn         (ARSTn),
    .RX_P_DATA     (RX_P_DATA),
    .RX_D_VLD      (RX_D_VLD),
    .RF_Address    (RF_Address),
    .RF_WrEn       (RF_WrEn),
    .RF_RdEn       (RF_RdEn),
    .RF_WrData     (RF_WrData),
    .RF_RdData     (RF_RdData),
    .RF_RdData_VLD (RF_RdData_VLD),
    .ALU_EN        (ALU_EN),
    .ALU_FUN       (ALU_FUN),
    .ALU_OUT       (ALU_OUT),
    .ALU_OUT_VLD   (ALU_OUT_VLD),
    .CLKG_EN       (CLKG_EN),
    .TXF_WR_DATA   (TXF_WR_DATA),
    .TXF_WR_INC    (TXF_WR_INC),
    .TXF_FULL      (TXF_FULL)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Observed transactions, collected at the falling edge.
  int   cyc = 0;
  logic full_s = 1'b0;
  int   full_viol = 0;
  int   wr_q[$], rd_q[$], alu_q[$], tx_q[$], tx_cyc_q[$];
  logic tog_on = 1'b0;
  logic [7:0] mem [16];

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    full_s <= TXF_FULL;
  end

  always @(negedge clk) begin
    if (ARSTn) begin
      if (RF_WrEn) wr_q.push_back(int'({RF_Address, RF_WrData}));
      if (RF_RdEn) rd_q.push_back(int'(RF_Address));
      if (ALU_EN)  alu_q.push_back(int'(ALU_FUN));
      if (TXF_WR_INC) begin
        tx_q.push_back(int'(TXF_WR_DATA));
        tx_cyc_q.push_back(cyc);
        if (full_s) full_viol++;
      end
    end
  end

  function automatic string q2s(input int q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%0h ", q[i])};
    return s;
  endfunction

  function automatic int min_gap(input int q[$]);
    int g = 1000;
    for (int i = 1; i < q.size(); i++) if (q[i] - q[i-1] < g) g = q[i] - q[i-1];
    return g;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    wr_q.delete(); rd_q.delete(); alu_q.delete(); tx_q.delete(); tx_cyc_q.delete();
    full_viol = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick(1);
    RX_D_VLD  = 1'b0;
    RX_P_DATA = 8'($urandom);
  endtask

  task automatic rd_valid(input logic [7:0] d);
    RF_RdData     = d;
    RF_RdData_VLD = 1'b1;
    tick(1);
    RF_RdData_VLD = 1'b0;
  endtask

  task automatic alu_valid(input logic [15:0] r);
    ALU_OUT     = r;
    ALU_OUT_VLD = 1'b1;
    tick(1);
    ALU_OUT_VLD = 1'b0;
  endtask

  task automatic test_reset();
    ARSTn = 1'b0;
    tick(2);
    n_chk++; if ({RF_WrEn, RF_RdEn, ALU_EN, TXF_WR_INC, CLKG_EN} !== 5'b0) $display("FAIL reset_strobes: got %b exp 00000", {RF_WrEn, RF_RdEn, ALU_EN, TXF_WR_INC, CLKG_EN}); else n_pass++;
    n_chk++; if ({RF_Address, RF_WrData} !== 12'h0) $display("FAIL reset_rf_outs: got %h exp 000", {RF_Address, RF_WrData}); else n_pass++;
    n_chk++; if ({ALU_FUN, TXF_WR_DATA} !== 12'h0) $display("FAIL reset_alu_tx_outs: got %h exp 000", {ALU_FUN, TXF_WR_DATA}); else n_pass++;
    ARSTn = 1'b1;
    tick(2);
  endtask

  task automatic test_rf_write(input logic [7:0] a, input logic [7:0] d);
    string exp_wr;
    clear_q();
    exp_wr = $sformatf("%0h ", (int'(a[3:0]) << 8) | int'(d));
    send_byte(8'hAA); tick(1);
    send_byte(a);     tick(2);
    send_byte(d);
    tick(3);
    n_chk++; if (q2s(wr_q) != exp_wr) $display("FAIL rf_write_pulses: got '%s' exp '%s'", q2s(wr_q), exp_wr); else n_pass++;
    n_chk++; if (tx_q.size() + rd_q.size() + alu_q.size() != 0) $display("FAIL rf_write_side_effects: got %0d exp 0", tx_q.size() + rd_q.size() + alu_q.size()); else n_pass++;
    n_chk++; if (RF_WrData !== d) $display("FAIL rf_write_data_held: got %h exp %h", RF_WrData, d); else n_pass++;
  endtask

  task automatic test_bad_byte();
    clear_q();
    send_byte(8'h55);
    tick(3);
    n_chk++; if (wr_q.size() + rd_q.size() + alu_q.size() + tx_q.size() != 0) $display("FAIL bad_byte_ignored: got %0d events exp 0", wr_q.size() + rd_q.size() + alu_q.size() + tx_q.size()); else n_pass++;
    n_chk++; if (CLKG_EN !== 1'b0) $display("FAIL bad_byte_clkg: got %b exp 0", CLKG_EN); else n_pass++;
    test_rf_write(8'hF1, 8'hFF);
  endtask

  task automatic test_rf_read();
    clear_q();
    mem[5] = 8'h3C;
    send_byte(8'hBB); tick(1);
    send_byte(8'h05);
    tick(2);
    rd_valid(mem[5]);
    tick(4);
    n_chk++; if (q2s(rd_q) != "5 ") $display("FAIL rf_read_strobe: got '%s' exp '5 '", q2s(rd_q)); else n_pass++;
    n_chk++; if (q2s(tx_q) != "3c ") $display("FAIL rf_read_push: got '%s' exp '3c '", q2s(tx_q)); else n_pass++;
    test_rf_write(8'h02, 8'h77);
  endtask

  task automatic test_valid_same_cycle();
    clear_q();
    send_byte(8'hBB);
    send_byte(8'h07);
    rd_valid(8'hA5);
    tick(3);
    n_chk++; if (tx_q.size() != 0) $display("FAIL same_cycle_valid_ignored: got %0d pushes exp 0", tx_q.size()); else n_pass++;
    rd_valid(8'h5A);
    tick(4);
    n_chk++; if (q2s(tx_q) != "5a ") $display("FAIL same_cycle_later_capture: got '%s' exp '5a '", q2s(tx_q)); else n_pass++;
  endtask

  task automatic test_alu_op();
    clear_q();
    n_chk++; if (CLKG_EN !== 1'b0) $display("FAIL alu_clkg_idle: got %b exp 0", CLKG_EN); else n_pass++;
    send_byte(8'hCC);
    n_chk++; if (CLKG_EN !== 1'b1) $display("FAIL alu_clkg_op_a: got %b exp 1", CLKG_EN); else n_pass++;
    send_byte(8'h12); tick(1);
    send_byte(8'h34);
    send_byte(8'h02);
    tick(2);
    n_chk++; if (CLKG_EN !== 1'b1) $display("FAIL alu_clkg_wait: got %b exp 1", CLKG_EN); else n_pass++;
    n_chk++; if (ALU_FUN !== 4'h2) $display("FAIL alu_fun_held: got %h exp 2", ALU_FUN); else n_pass++;
    alu_valid(16'h0446);
    n_chk++; if (CLKG_EN !== 1'b0) $display("FAIL alu_clkg_send: got %b exp 0", CLKG_EN); else n_pass++;
    tick(5);
    n_chk++; if (q2s(wr_q) != "12 134 ") $display("FAIL alu_operand_writes: got '%s' exp '12 134 '", q2s(wr_q)); else n_pass++;
    n_chk++; if (q2s(alu_q) != "2 ") $display("FAIL alu_en_fun: got '%s' exp '2 '", q2s(alu_q)); else n_pass++;
    n_chk++; if (q2s(tx_q) != "46 4 ") $display("FAIL alu_pushes: got '%s' exp '46 4 '", q2s(tx_q)); else n_pass++;
    n_chk++; if (min_gap(tx_cyc_q) < 2) $display("FAIL alu_push_spacing: got %0d exp >=2", min_gap(tx_cyc_q)); else n_pass++;
  endtask

  task automatic test_alu_full();
    logic [15:0] r;
    string exp_tx;
    clear_q();
    r = 16'($urandom);
    exp_tx = $sformatf("%0h %0h ", r[7:0], r[15:8]);
    send_byte(8'hDD);
    n_chk++; if (CLKG_EN !== 1'b1) $display("FAIL full_clkg_op_fun: got %b exp 1", CLKG_EN); else n_pass++;
    send_byte(8'h03);
    tick(1);
    TXF_FULL = 1'b1;
    alu_valid(r);
    tick(10);
    n_chk++; if (tx_q.size() != 0) $display("FAIL full_no_push: got %0d pushes exp 0", tx_q.size()); else n_pass++;
    TXF_FULL = 1'b0;
    tick(6);
    n_chk++; if (q2s(tx_q) != exp_tx) $display("FAIL full_pushes: got '%s' exp '%s'", q2s(tx_q), exp_tx); else n_pass++;
    n_chk++; if (q2s(alu_q) != "3 ") $display("FAIL full_alu_fun: got '%s' exp '3 '", q2s(alu_q)); else n_pass++;
    n_chk++; if (full_viol != 0) $display("FAIL full_push_while_full: got %0d exp 0", full_viol); else n_pass++;
  endtask

  task automatic test_reset_mid();
    clear_q();
    send_byte(8'hCC);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h05);
    tick(2);
    ARSTn = 1'b0;
    #1;
    n_chk++; if ({RF_WrEn, RF_RdEn, ALU_EN, TXF_WR_INC, CLKG_EN} !== 5'b0) $display("FAIL midrst_strobes: got %b exp 00000", {RF_WrEn, RF_RdEn, ALU_EN, TXF_WR_INC, CLKG_EN}); else n_pass++;
    n_chk++; if ({RF_Address, RF_WrData, ALU_FUN, TXF_WR_DATA} !== 24'h0) $display("FAIL midrst_values: got %h exp 000000", {RF_Address, RF_WrData, ALU_FUN, TXF_WR_DATA}); else n_pass++;
    tick(1);
    ARSTn = 1'b1;
    tick(1);
    alu_valid(16'hBEEF);
    tick(6);
    n_chk++; if (tx_q.size() != 0) $display("FAIL midrst_no_push: got %0d pushes exp 0", tx_q.size()); else n_pass++;
    clear_q();
    mem[3] = 8'h9E;
    send_byte(8'hBB);
    send_byte(8'h03);
    tick(1);
    rd_valid(mem[3]);
    tick(4);
    n_chk++; if (q2s(rd_q) != "3 ") $display("FAIL midrst_read_strobe: got '%s' exp '3 '", q2s(rd_q)); else n_pass++;
    n_chk++; if (q2s(tx_q) != "9e ") $display("FAIL midrst_read_push: got '%s' exp '9e '", q2s(tx_q)); else n_pass++;
  endtask

  task automatic full_toggler();
    int run = 0;
    while (tog_on) begin
      if (run >= 3) begin
        TXF_FULL = 1'b0;
        run = 0;
      end else begin
        TXF_FULL = ($urandom_range(0, 2) == 0);
        run = TXF_FULL ? run + 1 : 0;
      end
      tick(1);
    end
    TXF_FULL = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    send_byte(b);
    tick($urandom_range(0, 2));
  endtask

  // Randomized command stream; expectations come from command semantics only.
  task automatic test_random();
    int exp_wr[$], exp_rd[$], exp_alu[$], exp_tx[$];
    logic [7:0]  a, b, f, j;
    logic [15:0] r;
    clear_q();
    foreach (mem[i]) mem[i] = 8'($urandom);
    tog_on = 1'b1;
    fork full_toggler(); join_none
    for (int it = 0; it < 24; it++) begin
      a = 8'($urandom); b = 8'($urandom); f = 8'($urandom);
      case ($urandom_range(0, 4))
        0: begin
          send_gap(8'hAA); send_gap(a); send_byte(b);
          exp_wr.push_back((int'(a[3:0]) << 8) | int'(b));
          mem[a[3:0]] = b;
          tick(3);
        end
        1: begin
          send_gap(8'hBB); send_byte(a);
          exp_rd.push_back(int'(a[3:0]));
          tick($urandom_range(1, 4));
          rd_valid(mem[a[3:0]]);
          exp_tx.push_back(int'(mem[a[3:0]]));
          tick(25);
        end
        2, 3: begin
          if (f[0]) begin
            send_gap(8'hCC); send_gap(a); send_gap(b);
            exp_wr.push_back(int'(a));
            exp_wr.push_back((1 << 8) | int'(b));
            mem[0] = a;
            mem[1] = b;
          end else begin
            send_gap(8'hDD);
          end
          send_byte(f);
          exp_alu.push_back(int'(f[3:0]));
          tick($urandom_range(1, 4));
          r = 16'($urandom);
          alu_valid(r);
          exp_tx.push_back(int'(r[7:0]));
          exp_tx.push_back(int'(r[15:8]));
          tick(25);
        end
        default: begin
          j = 8'($urandom);
          while (j inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) j = 8'($urandom);
          send_byte(j);
          tick(2);
        end
      endcase
    end
    tog_on = 1'b0;
    tick(3);
    n_chk++; if (q2s(wr_q) != q2s(exp_wr)) $display("FAIL rand_rf_writes: got '%s' exp '%s'", q2s(wr_q), q2s(exp_wr)); else n_pass++;
    n_chk++; if (q2s(rd_q) != q2s(exp_rd)) $display("FAIL rand_rf_reads: got '%s' exp '%s'", q2s(rd_q), q2s(exp_rd)); else n_pass++;
    n_chk++; if (q2s(alu_q) != q2s(exp_alu)) $display("FAIL rand_alu_ops: got '%s' exp '%s'", q2s(alu_q), q2s(exp_alu)); else n_pass++;
    n_chk++; if (q2s(tx_q) != q2s(exp_tx)) $display("FAIL rand_tx_bytes: got '%s' exp '%s'", q2s(tx_q), q2s(exp_tx)); else n_pass++;
    n_chk++; if (full_viol != 0) $display("FAIL rand_push_while_full: got %0d exp 0", full_viol); else n_pass++;
    n_chk++; if (min_gap(tx_cyc_q) < 2) $display("FAIL rand_push_spacing: got %0d exp >=2", min_gap(tx_cyc_q)); else n_pass++;
  endtask

  initial begin
    ARSTn         = 1'b0;
    RX_P_DATA     = '0;
    RX_D_VLD      = 1'b0;
    RF_RdData     = '0;
    RF_RdData_VLD = 1'b0;
    ALU_OUT       = '0;
    ALU_OUT_VLD   = 1'b0;
    TXF_FULL      = 1'b0;
    foreach (mem[i]) mem[i] = 8'h00;

    test_reset();
    test_rf_write(8'h05, 8'h3C);
    test_rf_read();
    test_valid_same_cycle();
    test_alu_op();
    test_alu_full();
    test_bad_byte();
    test_reset_mid();
    test_random();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
